// File: rtl/pcie_ss_axis_tx_arb.sv
// Packet-atomic round-robin arbiter merging NUM_SRC AXI-Stream TX requesters onto one registered output.
// Optional feature: define PCIE_SS_TX_ARB_PKT_CNT_EN to add per-source accepted-packet counters (pkt_cnt).
module pcie_ss_axis_tx_arb #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              in_tvalid,
    output logic [NUM_SRC-1:0]              in_tready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_tdata,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0] in_tkeep,
    input  logic [NUM_SRC*USER_WIDTH-1:0]   in_tuser,
    input  logic [NUM_SRC-1:0]              in_tlast,
    output logic                            out_tvalid,
    output logic                            out_tlast,
    output logic [DATA_WIDTH-1:0]           out_tdata,
    output logic [DATA_WIDTH/8-1:0]         out_tkeep,
    output logic [USER_WIDTH-1:0]           out_tuser,
    input  logic                            out_tready,
    output logic [$clog2(NUM_SRC)-1:0]      grant_idx,
    output logic                            busy
`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
    ,
    output logic [NUM_SRC*32-1:0]           pkt_cnt
`endif
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [IDX_W-1:0]      w_src;
    logic [IDX_W-1:0]      w_src_inc;
    logic                  w_sel_found;
    logic                  w_src_ok;
    logic                  w_pipe_ok;
    logic                  w_acc_en;
    logic                  w_acc;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [KEEP_W-1:0]     w_keep;
    logic [USER_WIDTH-1:0] w_user;
    logic                  r_out_tvalid;
    logic                  r_out_tlast;
    logic [DATA_WIDTH-1:0] r_out_tdata;
    logic [KEEP_W-1:0]     r_out_tkeep;
    logic [USER_WIDTH-1:0] r_out_tuser;

    // Round-robin search for the first valid source at or after r_rr_ptr (only used while IDLE).
    always_comb begin
        logic [IDX_W:0]   v_sum;
        logic [IDX_W-1:0] v_idx;
        w_sel_found = 1'b0;
        w_sel_idx   = {IDX_W{1'b0}};
        v_sum       = {(IDX_W+1){1'b0}};
        v_idx       = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            v_idx = (v_sum >= (IDX_W+1)'(NUM_SRC)) ? IDX_W'(v_sum - (IDX_W+1)'(NUM_SRC))
                                                   : v_sum[IDX_W-1:0];
            if (!w_sel_found && in_tvalid[v_idx]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = v_idx;
            end else begin
                w_sel_found = w_sel_found;
            end
        end
    end

    // A locked packet owns the path even while its source bubbles.
    assign w_src     = (r_state == ST_LOCKED) ? r_grant_idx : w_sel_idx;
    assign w_src_ok  = (r_state == ST_LOCKED) | w_sel_found;
    assign w_pipe_ok = ~r_out_tvalid | out_tready;
    assign w_acc_en  = rst_n & w_pipe_ok & w_src_ok;
    assign w_acc     = w_acc_en & in_tvalid[w_src];
    assign w_last    = in_tlast[w_src];
    assign w_src_inc = (w_src == IDX_W'(NUM_SRC - 1)) ? {IDX_W{1'b0}} : (w_src + IDX_W'(1));

    // One-hot ready towards the current source, held low during reset.
    always_comb begin
        in_tready = {NUM_SRC{1'b0}};
        if (w_acc_en) begin
            in_tready[w_src] = 1'b1;
        end else begin
            in_tready = {NUM_SRC{1'b0}};
        end
    end

    // Payload mux from the current source.
    always_comb begin
        w_dat  = {DATA_WIDTH{1'b0}};
        w_keep = {KEEP_W{1'b0}};
        w_user = {USER_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_src == IDX_W'(i)) begin
                w_dat  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_keep = in_tkeep[i*KEEP_W +: KEEP_W];
                w_user = in_tuser[i*USER_WIDTH +: USER_WIDTH];
            end else begin
                w_dat  = w_dat;
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: lock on a non-final first beat, release on any accepted final beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && !w_last) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_acc && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant and round-robin pointer bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_idx <= {IDX_W{1'b0}};
            r_rr_ptr    <= {IDX_W{1'b0}};
        end else begin
            if (w_acc) begin
                r_grant_idx <= w_src;
            end
            if (w_acc && w_last) begin
                r_rr_ptr <= w_src_inc;
            end
        end
    end

    // Output register slice: load on accept, drop valid on a drained handshake, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_tvalid <= 1'b0;
            r_out_tlast  <= 1'b0;
            r_out_tdata  <= {DATA_WIDTH{1'b0}};
            r_out_tkeep  <= {KEEP_W{1'b0}};
            r_out_tuser  <= {USER_WIDTH{1'b0}};
        end else if (w_acc) begin
            r_out_tvalid <= 1'b1;
            r_out_tlast  <= w_last;
            r_out_tdata  <= w_dat;
            r_out_tkeep  <= w_keep;
            r_out_tuser  <= w_user;
        end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    assign out_tvalid = r_out_tvalid;
    assign out_tlast  = r_out_tlast;
    assign out_tdata  = r_out_tdata;
    assign out_tkeep  = r_out_tkeep;
    assign out_tuser  = r_out_tuser;
    assign grant_idx  = r_grant_idx;
    assign busy       = (r_state == ST_LOCKED);

`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
    logic [31:0] r_pkt_cnt [NUM_SRC];

    // Per-source count of accepted end-of-packet beats, wrapping naturally.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_n) begin
                r_pkt_cnt[i] <= 32'd0;
            end else if (w_acc && w_last && (w_src == IDX_W'(i))) begin
                r_pkt_cnt[i] <= r_pkt_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pkt_cnt
        assign pkt_cnt[g*32 +: 32] = r_pkt_cnt[g];
    end
`endif

endmodule

// File: tb/tb_pcie_ss_axis_tx_arb.sv
// Randomized and directed bench for pcie_ss_axis_tx_arb against a rule-level reference model.
module tb_pcie_ss_axis_tx_arb;
    localparam int N  = 4;
    localparam int DW = 512;
    localparam int UW = 10;
    localparam int KW = DW / 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_tvalid = '0;
    logic [N-1:0]    in_tready;
    logic [N*DW-1:0] in_tdata = '0;
    logic [N*KW-1:0] in_tkeep = '0;
    logic [N*UW-1:0] in_tuser = '0;
    logic [N-1:0]    in_tlast = '0;
    logic            out_tvalid, out_tlast;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic [UW-1:0]   out_tuser;
    logic            out_tready = 1'b0;
    logic [IW-1:0]   grant_idx;
    logic            busy;
`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    pcie_ss_axis_tx_arb #(.NUM_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tready(out_tready),
        .grant_idx(grant_idx), .busy(busy)
`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source traffic generators
    int pk_left[N], plen_fix[N], p_valid[N], dly[N], beat[N], plen[N], pktno[N];
    int drop_at[N], drop_len[N], drop_cnt[N];
    bit started[N], hs[N];
    int ready_mode = 0;
    bit want_rst = 1'b1;
    bit tog = 1'b0;

    // Reference model state
    bit             m_locked = 0;
    int             m_owner = 0, m_rr = 0, m_grant = 0;
    bit             m_ov = 0, m_ol = 0;
    logic [DW-1:0]  m_od = '0;
    logic [KW-1:0]  m_ok = '0;
    logic [UW-1:0]  m_ou = '0;
    logic [31:0]    m_pkt[N];

    // Output observation
    int q_src[$];
    int out_beats = 0, cyc = 0, first_hs = -1, last_hs = -1, prev_src = 0;
    bit prev_mid = 0;

    function automatic logic [DW-1:0] make_data(input int s, input int p, input int b);
        logic [31:0] w;
        w = {s[7:0], p[11:0], b[11:0]};
        return {16{w}};
    endfunction

    task automatic clear_setup();
        for (int i = 0; i < N; i++) begin
            pk_left[i] = 0; plen_fix[i] = 0; p_valid[i] = 100; dly[i] = 0;
            drop_at[i] = -1; drop_len[i] = 0;
        end
        q_src.delete();
        out_beats = 0; first_hs = -1; last_hs = -1;
    endtask

    task automatic drive();
        rst_n = !want_rst;
        for (int i = 0; i < N; i++) begin
            if (want_rst) begin
                started[i] = 0; beat[i] = 0; pk_left[i] = 0;
            end else if (hs[i]) begin
                if (beat[i] == plen[i] - 1) begin
                    started[i] = 0; beat[i] = 0; pk_left[i]--; pktno[i]++;
                end else begin
                    beat[i]++;
                end
            end
            if (!started[i] && pk_left[i] > 0) begin
                if (dly[i] > 0) dly[i]--;
                else begin
                    started[i] = 1; drop_cnt[i] = 0;
                    plen[i] = (plen_fix[i] > 0) ? plen_fix[i] : int'($urandom_range(1, 5));
                end
            end
            if (started[i] && drop_at[i] == beat[i] && drop_cnt[i] < drop_len[i]) begin
                drop_cnt[i]++;
                in_tvalid[i] = 1'b0;
            end else begin
                in_tvalid[i] = started[i] && (int'($urandom_range(0, 99)) < p_valid[i]);
            end
            in_tlast[i] = (beat[i] == plen[i] - 1);
            in_tdata[i*DW +: DW] = make_data(i, pktno[i], beat[i]);
            in_tkeep[i*KW +: KW] = {8{8'(i + 1), 8'(beat[i]), 16'(pktno[i]), 32'(~beat[i])}};
            in_tuser[i*UW +: UW] = UW'({i[1:0], pktno[i][3:0], beat[i][3:0]});
        end
        tog = !tog;
        case (ready_mode)
            0: out_tready = 1'b1;
            1: out_tready = tog;
            default: out_tready = ($urandom_range(0, 99) < 70);
        endcase
    endtask

    task automatic cycle();
        int src, s;
        bit have, acc, pipe_ok;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        check("out_tvalid", out_tvalid, m_ov);
        check("out_tlast", out_tlast, m_ol);
        check("out_tdata", out_tdata, m_od);
        check("out_tkeep", out_tkeep, m_ok);
        check("out_tuser", out_tuser, m_ou);
        check("grant_idx", grant_idx, m_grant);
        check("busy", busy, m_locked);
`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
        for (int i = 0; i < N; i++) check("pkt_cnt", pkt_cnt[i*32 +: 32], m_pkt[i]);
`endif
        drive();
        #1;
        pipe_ok = !m_ov || out_tready;
        have = 0; src = 0;
        if (m_locked) begin
            have = 1; src = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!have && in_tvalid[(m_rr + k) % N]) begin
                    have = 1; src = (m_rr + k) % N;
                end
            end
        end
        exp_rdy = '0;
        if (rst_n && pipe_ok && have) exp_rdy[src] = 1'b1;
        check("in_tready", in_tready, exp_rdy);
        acc = rst_n && pipe_ok && have && in_tvalid[src];
        for (int i = 0; i < N; i++) hs[i] = in_tvalid[i] && in_tready[i];
        if (rst_n && out_tvalid && out_tready) begin
            s = int'(out_tdata[31:24]);
            if (prev_mid) check("no_interleave", s, prev_src);
            prev_mid = !out_tlast; prev_src = s;
            out_beats++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (out_tlast) q_src.push_back(s);
        end
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_grant = 0;
            m_ov = 0; m_ol = 0; m_od = '0; m_ok = '0; m_ou = '0; prev_mid = 0;
            for (int i = 0; i < N; i++) m_pkt[i] = 32'd0;
        end else if (acc) begin
            m_ov = 1; m_ol = in_tlast[src];
            m_od = in_tdata[src*DW +: DW];
            m_ok = in_tkeep[src*KW +: KW];
            m_ou = in_tuser[src*UW +: UW];
            m_grant = src;
            if (in_tlast[src]) begin
                m_locked = 0; m_rr = (src + 1) % N; m_pkt[src] = m_pkt[src] + 32'd1;
            end else begin
                m_locked = 1; m_owner = src;
            end
        end else if (out_tready) begin
            m_ov = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cnt3;
        for (int i = 0; i < N; i++) begin
            m_pkt[i] = 32'd0; pktno[i] = 0; beat[i] = 0; plen[i] = 1; started[i] = 0; hs[i] = 0;
        end
        clear_setup();
        want_rst = 1'b1;
        run(3);
        want_rst = 1'b0;
        run(2);

        // All four sources, 3-beat packets, continuous ready
        clear_setup();
        for (int i = 0; i < N; i++) begin pk_left[i] = 1; plen_fix[i] = 3; end
        pk_left[0] = 2;
        run(25);
        check("a_pkts", q_src.size(), 5);
        for (int k = 0; k < 5; k++) check("a_order", q_src[k], k % 4);
        check("a_beats", out_beats, 15);
        check("a_b2b", last_hs - first_hs + 1, 15);

        // src1 5-beat packet, src0 arrives mid-packet, src2 idle
        clear_setup();
        pk_left[1] = 1; plen_fix[1] = 5;
        pk_left[0] = 1; plen_fix[0] = 3; dly[0] = 2;
        run(20);
        check("b_pkts", q_src.size(), 2);
        check("b_first", q_src[0], 1);
        check("b_second", q_src[1], 0);

        // 4-beat packet under alternating downstream ready
        clear_setup();
        pk_left[2] = 1; plen_fix[2] = 4; ready_mode = 1;
        run(20);
        check("c_pkts", q_src.size(), 1);
        check("c_beats", out_beats, 4);
        ready_mode = 0;

        // Reset after the second beat of a src3 4-beat packet
        clear_setup();
        pk_left[3] = 1; plen_fix[3] = 4;
        cnt3 = 0;
        for (int t = 0; t < 50 && cnt3 < 2; t++) begin
            cycle();
            if (hs[3]) cnt3++;
        end
        check("d_two_beats", cnt3, 2);
        want_rst = 1'b1;
        cycle();
        want_rst = 1'b0;
        clear_setup();
        cycle();
        check("d_rst_valid", out_tvalid, 1'b0);
        check("d_rst_busy", busy, 1'b0);
        pk_left[0] = 1; plen_fix[0] = 2;
        pk_left[1] = 1; plen_fix[1] = 2;
        run(15);
        check("d_pkts", q_src.size(), 2);
        check("d_first", q_src[0], 0);

        // Ten single-beat packets from src2 only
        clear_setup();
        pk_left[2] = 10; plen_fix[2] = 1;
        run(40);
        check("e_pkts", q_src.size(), 10);
        for (int k = 0; k < 10; k++) check("e_src", q_src[k], 2);
`ifdef PCIE_SS_TX_ARB_PKT_CNT_EN
        check("e_pkt_cnt2", pkt_cnt[2*32 +: 32], 10);
`endif

        // Granted src0 bubbles for 3 cycles mid-packet while src1 waits
        clear_setup();
        pk_left[0] = 1; plen_fix[0] = 5; drop_at[0] = 2; drop_len[0] = 3;
        pk_left[1] = 1; plen_fix[1] = 2; dly[1] = 1;
        run(30);
        check("f_pkts", q_src.size(), 2);
        check("f_first", q_src[0], 0);
        check("f_second", q_src[1], 1);

        // Randomized traffic with random lengths, bubbles and backpressure
        clear_setup();
        for (int i = 0; i < N; i++) begin pk_left[i] = 100000; p_valid[i] = 80; end
        ready_mode = 2;
        run(3000);
        for (int i = 0; i < N; i++) begin pk_left[i] = started[i] ? 1 : 0; p_valid[i] = 100; end
        ready_mode = 0;
        run(30);
        check("g_drained", out_tvalid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
